// File: rtl/kernel_rotation_buffer.sv
// Kernel rotation buffer: NUM_BLOCKS independently loadable kernel blocks, recirculated non-destructively.
// Optional macro KRB_ERR_CHECK_EN adds a sticky err output for illegal loads and rotates.
module kernel_rotation_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_BLOCKS = 12,
  parameter int LANES      = 3,
  parameter int DEPTH      = 8,
  parameter int BLK_W      = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1,
  parameter int PH_W       = $clog2(DEPTH)
) (
  input  logic                                   clk,
  input  logic                                   arst_n_in,
  input  logic                                   clear,
  input  logic                                   load_valid,
  output logic                                   load_ready,
  input  logic [BLK_W-1:0]                       load_block,
  input  logic [LANES*DATA_WIDTH-1:0]            load_data,
  input  logic                                   rotate,
  output logic [NUM_BLOCKS*LANES*DATA_WIDTH-1:0] out,
  output logic [NUM_BLOCKS-1:0]                  block_full,
  output logic                                   all_full,
  output logic [PH_W-1:0]                        phase,
  output logic                                   phase_wrap
`ifdef KRB_ERR_CHECK_EN
  ,
  output logic                                   err
`endif
);
  localparam int ROW_W = LANES * DATA_WIDTH;
  localparam int CNT_W = PH_W + 1;

  logic            in_range;
  logic            sel_full;
  logic            load_fire;
  logic            rotate_en;
  logic [PH_W-1:0] phase_reg;
  logic            phase_wrap_reg;

  assign in_range = int'(load_block) < NUM_BLOCKS;

  always_comb begin
    sel_full = 1'b0;
    for (int b = 0; b < NUM_BLOCKS; b++) begin
      if (int'(load_block) == b) sel_full = block_full[b];
    end
  end

  // Reset is folded in so no beat can appear accepted while the block is held in reset.
  assign load_ready = arst_n_in && !clear && in_range && !sel_full;
  assign load_fire  = load_valid && load_ready;
  assign rotate_en  = rotate && !clear;
  assign all_full   = &block_full;
  assign phase      = phase_reg;
  assign phase_wrap = phase_wrap_reg;

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      phase_reg      <= '0;
      phase_wrap_reg <= 1'b0;
    end else if (clear || !all_full) begin
      phase_reg      <= '0;
      phase_wrap_reg <= 1'b0;
    end else if (rotate) begin
      phase_reg      <= phase_reg + 1'b1;
      phase_wrap_reg <= (phase_reg == PH_W'(DEPTH - 1));
    end else begin
      phase_wrap_reg <= 1'b0;
    end
  end

`ifdef KRB_ERR_CHECK_EN
  logic err_reg;
  assign err = err_reg;

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      err_reg <= 1'b0;
    end else if (clear) begin
      err_reg <= 1'b0;
    end else if ((load_valid && (!in_range || sel_full)) || (rotate && !all_full)) begin
      err_reg <= 1'b1;
    end
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BLOCKS; gi++) begin : g_blk
      logic [ROW_W-1:0] mem [DEPTH];
      logic [PH_W-1:0]  wr_ptr_reg;
      logic [PH_W-1:0]  rd_ptr_reg;
      logic [PH_W-1:0]  rd_ptr_next;
      logic [CNT_W-1:0] count_reg;
      logic [ROW_W-1:0] out_reg;
      logic             load_hit;
      logic             rot_hit;

      assign block_full[gi]            = (count_reg == CNT_W'(DEPTH));
      assign load_hit                  = load_fire && (int'(load_block) == gi);
      assign rot_hit                   = rotate_en && block_full[gi];
      assign rd_ptr_next               = rd_ptr_reg + 1'b1;
      assign out[gi*ROW_W +: ROW_W]    = out_reg;

      always_ff @(posedge clk) begin
        if (load_hit) mem[wr_ptr_reg] <= load_data;
      end

      // A load and a rotate never hit the same block: a rotating block is full and refuses loads.
      always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
          out_reg    <= '0;
        end else if (clear) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
          out_reg    <= '0;
        end else begin
          if (load_hit) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
            count_reg  <= count_reg + 1'b1;
            if (count_reg == '0) out_reg <= load_data;
          end
          if (rot_hit) begin
            rd_ptr_reg <= rd_ptr_next;
            out_reg    <= mem[rd_ptr_next];
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_kernel_rotation_buffer.sv
// Randomised scoreboard bench for kernel_rotation_buffer against a queue/array reference model.
// Honours KRB_ERR_CHECK_EN so the err port is connected and modelled when the macro is set.
module tb_kernel_rotation_buffer;
  localparam int DW    = 16;
  localparam int NB    = 12;
  localparam int LN    = 3;
  localparam int DEPTH = 8;
  localparam int BLK_W = 4;
  localparam int PH_W  = 3;
  localparam int ROW_W = LN * DW;
  localparam int OUT_W = NB * ROW_W;

  logic              clk = 1'b0;
  logic              arst_n_in;
  logic              clear;
  logic              load_valid;
  logic              load_ready;
  logic [BLK_W-1:0]  load_block;
  logic [ROW_W-1:0]  load_data;
  logic              rotate;
  logic [OUT_W-1:0]  out;
  logic [NB-1:0]     block_full;
  logic              all_full;
  logic [PH_W-1:0]   phase;
  logic              phase_wrap;
`ifdef KRB_ERR_CHECK_EN
  logic              err;
`endif

  kernel_rotation_buffer #(
    .DATA_WIDTH(DW), .NUM_BLOCKS(NB), .LANES(LN), .DEPTH(DEPTH), .BLK_W(BLK_W), .PH_W(PH_W)
  ) dut (
    .clk(clk), .arst_n_in(arst_n_in), .clear(clear),
    .load_valid(load_valid), .load_ready(load_ready), .load_block(load_block),
    .load_data(load_data), .rotate(rotate), .out(out), .block_full(block_full),
    .all_full(all_full), .phase(phase), .phase_wrap(phase_wrap)
`ifdef KRB_ERR_CHECK_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_W-1:0] out;
    logic [NB-1:0]    full;
    logic             af;
    logic [PH_W-1:0]  ph;
    logic             wrap;
    logic             err;
  } snap_t;

  snap_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: stored kernel rows, fill counts, rotation offsets, rotations since all blocks filled.
  logic [ROW_W-1:0] words [NB][DEPTH];
  int  cnt  [NB];
  int  rofs [NB];
  int  since;
  logic wrap_m;
  logic err_m;

  task automatic chk(input string name, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic model_all_full();
    for (int b = 0; b < NB; b++) if (cnt[b] != DEPTH) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear();
    for (int b = 0; b < NB; b++) begin
      cnt[b]  = 0;
      rofs[b] = 0;
    end
    since  = 0;
    wrap_m = 1'b0;
    err_m  = 1'b0;
  endtask

  function automatic snap_t expected_snap();
    snap_t s;
    s.out = '0;
    for (int b = 0; b < NB; b++) begin
      if (cnt[b] > 0) s.out[b*ROW_W +: ROW_W] = words[b][rofs[b]];
      s.full[b] = (cnt[b] == DEPTH);
    end
    s.af   = model_all_full();
    s.ph   = PH_W'(since % DEPTH);
    s.wrap = wrap_m;
    s.err  = err_m;
    return s;
  endfunction

  function automatic logic [ROW_W-1:0] mk_row(input int base, input int stride);
    logic [ROW_W-1:0] r;
    for (int l = 0; l < LN; l++) r[l*DW +: DW] = DW'(base + l * stride);
    return r;
  endfunction

  // One clock of stimulus: check the combinational ready, advance the model, queue the expected outputs.
  task automatic step(input logic lv, input logic [BLK_W-1:0] lb, input logic [ROW_W-1:0] ld,
                      input logic rot, input logic clr);
    logic exp_rdy;
    logic af_before;
    int   lbi;
    @(negedge clk);
    load_valid = lv; load_block = lb; load_data = ld; rotate = rot; clear = clr;
    #1;
    lbi       = int'(lb);
    af_before = model_all_full();
    exp_rdy   = !clr && ((lbi < NB) ? (cnt[lbi] != DEPTH) : 1'b0);
    chk("load_ready", OUT_W'(load_ready), OUT_W'(exp_rdy));
    if (clr) begin
      model_clear();
    end else begin
      if ((lv && !exp_rdy) || (rot && !af_before)) err_m = 1'b1;
      wrap_m = 1'b0;
      if (rot) begin
        for (int b = 0; b < NB; b++) if (cnt[b] == DEPTH) rofs[b] = (rofs[b] + 1) % DEPTH;
      end
      if (lv && exp_rdy) begin
        words[lbi][cnt[lbi]] = ld;
        cnt[lbi]++;
      end
      if (rot && af_before) begin
        since++;
        wrap_m = (since % DEPTH == 0);
      end
      if (!model_all_full()) since = 0;
    end
    q.push_back(expected_snap());
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic fill_block(input int b, input int beats, input int base, input int stride);
    for (int k = 0; k < beats; k++) step(1'b1, BLK_W'(b), mk_row(base + k, stride), 1'b0, 1'b0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, " out"},        out,                OUT_W'(0));
    chk({tag, " block_full"}, OUT_W'(block_full), OUT_W'(0));
    chk({tag, " all_full"},   OUT_W'(all_full),   OUT_W'(0));
    chk({tag, " phase"},      OUT_W'(phase),      OUT_W'(0));
    chk({tag, " phase_wrap"}, OUT_W'(phase_wrap), OUT_W'(0));
    chk({tag, " load_ready"}, OUT_W'(load_ready), OUT_W'(0));
  endtask

  // Monitor: every edge that has a queued expectation is compared just after the edge.
  initial begin
    snap_t s;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        s = q.pop_front();
        chk("out",        out,                s.out);
        chk("block_full", OUT_W'(block_full), OUT_W'(s.full));
        chk("all_full",   OUT_W'(all_full),   OUT_W'(s.af));
        chk("phase",      OUT_W'(phase),      OUT_W'(s.ph));
        chk("phase_wrap", OUT_W'(phase_wrap), OUT_W'(s.wrap));
`ifdef KRB_ERR_CHECK_EN
        chk("err",        OUT_W'(err),        OUT_W'(s.err));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    arst_n_in = 1'b0; clear = 1'b0; load_valid = 1'b0; load_block = '0;
    load_data = '0; rotate = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    arst_n_in = 1'b1;
    idle();

    // Block 0 with {1,2,3},{4,5,6}..{22,23,24}, then confirm it refuses further beats.
    for (int k = 0; k < DEPTH; k++) step(1'b1, 4'd0, mk_row(3 * k + 1, 1), 1'b0, 1'b0);
    idle();

    // All blocks filled with 100*b+k, then a full revolution plus one.
    step(1'b0, '0, '0, 1'b0, 1'b1);
    for (int b = 0; b < NB; b++) fill_block(b, DEPTH, 100 * b, 1000);
    for (int r = 0; r < DEPTH + 1; r++) step(1'b0, '0, '0, 1'b1, 1'b0);
    idle();

    // Block 11 completes on the same edge the others rotate.
    step(1'b0, '0, '0, 1'b0, 1'b1);
    for (int b = 0; b < NB - 1; b++) fill_block(b, DEPTH, 100 * b, 1000);
    fill_block(NB - 1, DEPTH - 1, 1100, 1000);
    step(1'b1, 4'd11, mk_row(1107, 1000), 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Out-of-range block index, then clear racing a rotate and a load.
    step(1'b1, 4'd13, mk_row(7, 1), 1'b0, 1'b0);
    step(1'b1, 4'd13, mk_row(9, 1), 1'b1, 1'b0);
    step(1'b1, 4'd2, mk_row(5, 1), 1'b1, 1'b1);
    idle();

    // Asynchronous reset pulse in the middle of a load beat.
    fill_block(0, 3, 40, 1);
    @(negedge clk);
    load_valid = 1'b1; load_block = 4'd0; load_data = mk_row(99, 1);
    #2 arst_n_in = 1'b0;
    #1 check_zero_outputs("async_reset");
    model_clear();
    #4 arst_n_in = 1'b1;
    load_valid = 1'b0;
    fill_block(0, DEPTH, 500, 7);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Random traffic: mostly loads, frequent rotates, rare clears, some illegal block indices.
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 99) < 80, BLK_W'($urandom_range(0, 15)),
           ROW_W'({$urandom(), $urandom()}), $urandom_range(0, 99) < 35,
           $urandom_range(0, 199) == 0);
    end
    for (int b = 0; b < NB; b++) fill_block(b, DEPTH, $urandom_range(0, 30000), 3);
    for (int r = 0; r < 2 * DEPTH + 3; r++) step(1'b0, '0, '0, $urandom_range(0, 3) != 0, 1'b0);
    repeat (3) idle();

    @(posedge clk);
    #2;
    if (q.size() != 0) begin
      bad++;
      total++;
      $display("FAIL drain: pending=%0d expected=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
